// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver: received data plus status strobes.
// master = receiver (drives), slave = byte consumer.
interface uart_rx_if;
  logic [7:0] uart_dat_o;
  logic       uart_rdy_o;
  logic       uart_ferr_o;
  logic       uart_perr_o;
  logic       uart_busy_o;

  modport master (output uart_dat_o, uart_rdy_o, uart_ferr_o, uart_perr_o, uart_busy_o);
  modport slave  (input  uart_dat_o, uart_rdy_o, uart_ferr_o, uart_perr_o, uart_busy_o);
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled with 3-sample majority vote. 8N1 by default;
// define UART_RX_PARITY_EN for start + 8 data + even parity + stop.
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic     sys_clk_i,
  input  logic     sys_rst_i,
  input  logic     uart_rx_i,
  uart_rx_if.master bus
);

  localparam logic [31:0] INC = 32'(16 * BAUD);
  localparam logic [31:0] LIM = 32'(CLK_HZ);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta, rx_sync;
  logic [31:0] acc, acc_sum;
  logic        tick;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bitidx_q, bitidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  s_q, s_d, samp;
  logic        vote, vote_tick, end_tick;
  logic [7:0]  dat_q, dat_d;
  logic        rdy_q, rdy_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic        perr_q, perr_d;
  logic        perr_o_q, perr_o_d;
`endif

  // Fractional tick generator: free-running, so start alignment is within one tick.
  assign acc_sum = acc + INC;
  assign tick    = (acc_sum >= LIM);

  // Majority includes the sample being taken on the cnt=9 tick.
  assign samp      = {s_q[1:0], rx_sync};
  assign vote      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign vote_tick = tick && (cnt_q == 4'd9);
  assign end_tick  = tick && (cnt_q == 4'd15);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? 4'(cnt_q + 4'd1) : cnt_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    s_d      = (tick && cnt_q >= 4'd7 && cnt_q <= 4'd9) ? samp : s_q;
    dat_d    = dat_q;
    rdy_d    = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
    perr_o_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (vote_tick && vote) state_d = IDLE;
        else if (end_tick) begin
          state_d  = DATA;
          cnt_d    = 4'd0;
          bitidx_d = 3'd0;
        end
      end
      DATA: begin
        if (vote_tick) shreg_d = {vote, shreg_q[7:1]};
        if (end_tick) begin
          cnt_d = 4'd0;
          if (bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitidx_d = 3'(bitidx_q + 3'd1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote_tick) perr_d = vote ^ (^shreg_q);
        if (end_tick) begin
          state_d = STOP;
          cnt_d   = 4'd0;
        end
      end
`endif
      // Leave at the vote rather than the bit end so the next start edge is never missed.
      STOP: begin
        if (vote_tick) begin
          if (vote) begin
            dat_d   = shreg_q;
            rdy_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_o_d = perr_q;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = 4'd0;
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      acc      <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
      s_q      <= '0;
      dat_q    <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
      perr_o_q <= 1'b0;
`endif
    end else begin
      rx_meta  <= uart_rx_i;
      rx_sync  <= rx_meta;
      acc      <= tick ? acc_sum - LIM : acc_sum;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
      s_q      <= s_d;
      dat_q    <= dat_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
      perr_o_q <= perr_o_d;
`endif
    end
  end

  assign bus.uart_dat_o  = dat_q;
  assign bus.uart_rdy_o  = rdy_q;
  assign bus.uart_ferr_o = ferr_q;
  assign bus.uart_busy_o = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.uart_perr_o = perr_o_q;
`else
  assign bus.uart_perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames (nominal, +/-3% baud, framing error)
// plus hand-written glitch, mid-frame reset and parity sequences.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam real BIT_NS = 1.0e9 / 115200.0;

  logic sys_clk_i = 1'b0;
  logic sys_rst_i = 1'b1;
  logic uart_rx_i = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLK_HZ(50000000), .BAUD(115200)) dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .uart_rx_i (uart_rx_i),
    .bus       (bus)
  );

  always #10 sys_clk_i = ~sys_clk_i;

  typedef struct {
    logic [7:0] data;
    int         ppk;       // sender bit period in 1/1000 of nominal
    logic       stop;
    int         low_bits;  // extra line-low time after the stop bit
    int         gap_bits;
    int         exp_rdy;
    int         exp_ferr;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t vecs [9];
  int checks = 0;
  int errors = 0;

  int rdy_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int overlap = 0, wide = 0, perr_alone = 0, busy_bad = 0;
  logic prev_rdy = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;

  always @(negedge sys_clk_i) begin
    prev_rdy  <= bus.uart_rdy_o;
    prev_ferr <= bus.uart_ferr_o;
    prev_busy <= bus.uart_busy_o;
    if (!sys_rst_i) begin
      if (bus.uart_rdy_o) begin
        rdy_cnt <= rdy_cnt + 1;
        if (bus.uart_busy_o || !prev_busy) busy_bad <= busy_bad + 1;
      end
      if (bus.uart_ferr_o) ferr_cnt <= ferr_cnt + 1;
      if (bus.uart_perr_o) perr_cnt <= perr_cnt + 1;
      if (bus.uart_rdy_o && bus.uart_ferr_o) overlap <= overlap + 1;
      if (bus.uart_perr_o && !bus.uart_rdy_o) perr_alone <= perr_alone + 1;
      if ((bus.uart_rdy_o && prev_rdy) || (bus.uart_ferr_o && prev_ferr)) wide <= wide + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int ppk, input logic stop_v,
                            input logic par_flip);
    realtime bt;
    bt = BIT_NS * ppk / 1000.0;
    uart_rx_i = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = d[i];
      #(bt);
    end
    if (PAR_EN) begin
      uart_rx_i = (^d) ^ par_flip;
      #(bt);
    end
    uart_rx_i = stop_v;
    #(bt);
  endtask

  task automatic idle_bits(input int n);
    uart_rx_i = 1'b1;
    #(n * BIT_NS);
  endtask

  initial begin
    int r0, f0, p0;
    vecs[0] = '{8'h55, 1000, 1'b1, 0, 2, 1, 0, 8'h55};
    vecs[1] = '{8'h00,  970, 1'b1, 0, 0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF,  970, 1'b1, 0, 0, 1, 0, 8'hFF};
    vecs[3] = '{8'hA3,  970, 1'b1, 0, 2, 1, 0, 8'hA3};
    vecs[4] = '{8'h00, 1030, 1'b1, 0, 0, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1030, 1'b1, 0, 0, 1, 0, 8'hFF};
    vecs[6] = '{8'hA3, 1030, 1'b1, 0, 2, 1, 0, 8'hA3};
    vecs[7] = '{8'h3C, 1000, 1'b0, 2, 2, 0, 1, 8'hA3};
    vecs[8] = '{8'h81, 1000, 1'b1, 0, 2, 1, 0, 8'h81};

    repeat (4) @(posedge sys_clk_i);
    @(negedge sys_clk_i) sys_rst_i = 1'b0;
    repeat (2) @(negedge sys_clk_i);
    chk("reset_dat",  32'(bus.uart_dat_o),  32'h00);
    chk("reset_rdy",  32'(bus.uart_rdy_o),  32'h0);
    chk("reset_ferr", 32'(bus.uart_ferr_o), 32'h0);
    chk("reset_perr", 32'(bus.uart_perr_o), 32'h0);
    chk("reset_busy", 32'(bus.uart_busy_o), 32'h0);
    idle_bits(1);

    // Checks right after the stop bit are safe: the strobe lands ~0.4 bit earlier.
    for (int v = 0; v < 9; v++) begin
      r0 = rdy_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].ppk, vecs[v].stop, 1'b0);
      if (vecs[v].low_bits > 0) begin
        uart_rx_i = 1'b0;
        #(vecs[v].low_bits * BIT_NS);
      end
      if (vecs[v].gap_bits > 0) idle_bits(vecs[v].gap_bits);
      chk($sformatf("vec%0d_rdy", v),  32'(rdy_cnt - r0),  32'(vecs[v].exp_rdy));
      chk($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
      chk($sformatf("vec%0d_dat", v),  32'(bus.uart_dat_o), 32'(vecs[v].exp_dat));
    end

    // 100 ns low glitch on an idle line
    r0 = rdy_cnt;
    f0 = ferr_cnt;
    uart_rx_i = 1'b0;
    #100;
    uart_rx_i = 1'b1;
    #200;
    chk("glitch_busy_hi", 32'(bus.uart_busy_o), 32'h1);
    #(BIT_NS);
    chk("glitch_busy_lo", 32'(bus.uart_busy_o), 32'h0);
    chk("glitch_rdy",  32'(rdy_cnt - r0),  32'h0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);

    // One-clock reset during data bit 4; remaining bits are high so no false start follows.
    r0 = rdy_cnt;
    f0 = ferr_cnt;
    fork
      send_frame(8'hF5, 1000, 1'b1, 1'b0);
      begin
        #(5.5 * BIT_NS);
        @(negedge sys_clk_i);
        chk("rst_busy_before", 32'(bus.uart_busy_o), 32'h1);
        sys_rst_i = 1'b1;
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        chk("rst_busy_after", 32'(bus.uart_busy_o), 32'h0);
        chk("rst_dat_after",  32'(bus.uart_dat_o),  32'h00);
      end
    join
    idle_bits(2);
    chk("rst_rdy",  32'(rdy_cnt - r0),  32'h0);
    chk("rst_ferr", 32'(ferr_cnt - f0), 32'h0);
    chk("rst_dat",  32'(bus.uart_dat_o), 32'h00);
    r0 = rdy_cnt;
    send_frame(8'h7E, 1000, 1'b1, 1'b0);
    idle_bits(2);
    chk("post_rst_rdy", 32'(rdy_cnt - r0),  32'h1);
    chk("post_rst_dat", 32'(bus.uart_dat_o), 32'h7E);

`ifdef UART_RX_PARITY_EN
    r0 = rdy_cnt;
    p0 = perr_cnt;
    send_frame(8'h07, 1000, 1'b1, 1'b0);
    idle_bits(2);
    chk("par_ok_rdy",  32'(rdy_cnt - r0),  32'h1);
    chk("par_ok_perr", 32'(perr_cnt - p0), 32'h0);
    chk("par_ok_dat",  32'(bus.uart_dat_o), 32'h07);
    r0 = rdy_cnt;
    p0 = perr_cnt;
    send_frame(8'h07, 1000, 1'b1, 1'b1);
    idle_bits(2);
    chk("par_bad_rdy",  32'(rdy_cnt - r0),  32'h1);
    chk("par_bad_perr", 32'(perr_cnt - p0), 32'h1);
    chk("par_bad_dat",  32'(bus.uart_dat_o), 32'h07);
`else
    p0 = perr_cnt;
    chk("perr_tied_low", 32'(p0), 32'h0);
`endif

    chk("rdy_ferr_overlap", 32'(overlap),    32'h0);
    chk("strobe_width",     32'(wide),       32'h0);
    chk("perr_without_rdy", 32'(perr_alone), 32'h0);
    chk("busy_fall_at_rdy", 32'(busy_bad),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
